// File: rtl/trace_node_parser.sv
// Trace child-node stream parser: walks node headers, decodes the
// BasicInfo/Pc32/IntReg32/Io payloads into records and skips all others.
module trace_node_parser #(
    parameter logic [31:0] MAX_NODE_BYTES = 32'h0010_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [31:0] rec_type,
    output logic [31:0] rec_data0,
    output logic [31:0] rec_data1,
    output logic [31:0] rec_data2,
    output logic        node_done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [31:0] T_BASIC = 32'd1;
    localparam logic [31:0] T_PC    = 32'd2;
    localparam logic [31:0] T_INT   = 32'd4;
    localparam logic [31:0] T_IO    = 32'd12;

    typedef enum logic [2:0] {H0, H1, H2, H3, PAY, SKIP, ERR} state_t;

    state_t      state;
    logic [31:0] size_q;
    logic [31:0] type_q;
    logic [19:0] cnt;
    logic [4:0]  pos;
    logic        acc;

    // Zero means "not a recognised type".
    function automatic logic [31:0] req_size(input logic [31:0] t);
        case (t)
            T_BASIC: req_size = 32'd32;
            T_PC:    req_size = 32'd24;
            T_INT:   req_size = 32'd144;
            T_IO:    req_size = 32'd24;
            default: req_size = 32'd0;
        endcase
    endfunction

    assign in_ready = (state != ERR) && (!rec_valid || rec_ready);
    assign acc      = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= H0;
            size_q    <= '0;
            type_q    <= '0;
            cnt       <= '0;
            pos       <= '0;
            rec_valid <= 1'b0;
            rec_type  <= '0;
            rec_data0 <= '0;
            rec_data1 <= '0;
            rec_data2 <= '0;
            node_done <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
        end else begin
            node_done <= 1'b0;
            if (rec_valid && rec_ready)
                rec_valid <= 1'b0;
            if (acc) begin
                case (state)
                    H0: begin
                        size_q <= in_data;
                        state  <= H1;
                    end
                    H1: begin
                        if (in_data != 32'd0) begin
                            err      <= 1'b1;
                            err_code <= 2'd1;
                            state    <= ERR;
                        end else begin
                            state <= H2;
                        end
                    end
                    H2: begin
                        type_q <= in_data;
                        if (size_q < 32'd16 || size_q[1:0] != 2'b00 ||
                            size_q > MAX_NODE_BYTES) begin
                            err      <= 1'b1;
                            err_code <= 2'd2;
                            state    <= ERR;
                        end else if (req_size(in_data) != 32'd0 &&
                                     req_size(in_data) != size_q) begin
                            err      <= 1'b1;
                            err_code <= 2'd3;
                            state    <= ERR;
                        end else begin
                            state <= H3;
                        end
                    end
                    H3: begin
                        cnt <= size_q[21:2] - 20'd4;
                        pos <= '0;
                        if (size_q[21:2] == 20'd4) begin
                            node_done <= 1'b1;
                            state     <= H0;
                        end else if (req_size(type_q) != 32'd0) begin
                            state <= PAY;
                        end else begin
                            state <= SKIP;
                        end
                    end
                    PAY, SKIP: begin
                        cnt <= cnt - 20'd1;
                        pos <= pos + 5'd1;
                        if (cnt == 20'd1) begin
                            node_done <= 1'b1;
                            state     <= H0;
                        end
                        // Record register is free here: in_ready implies it.
                        if (state == PAY) begin
                            case (type_q)
                                T_BASIC: begin
                                    if (pos == 5'd0) rec_data0 <= in_data;
                                    if (pos == 5'd1) rec_data1 <= in_data;
                                    if (pos == 5'd2) rec_data2 <= in_data;
                                    if (pos == 5'd3) begin
                                        rec_type  <= T_BASIC;
                                        rec_valid <= 1'b1;
                                    end
                                end
                                T_PC: begin
                                    if (pos == 5'd0) rec_data0 <= in_data;
                                    if (pos == 5'd1) begin
                                        rec_data1 <= in_data;
                                        rec_data2 <= '0;
                                        rec_type  <= T_PC;
                                        rec_valid <= 1'b1;
                                    end
                                end
                                T_IO: begin
                                    if (pos == 5'd0) begin
                                        rec_data0 <= in_data;
                                        rec_data1 <= '0;
                                        rec_data2 <= '0;
                                        rec_type  <= T_IO;
                                        rec_valid <= 1'b1;
                                    end
                                end
                                default: begin
                                    rec_data0 <= {27'd0, pos};
                                    rec_data1 <= in_data;
                                    rec_data2 <= '0;
                                    rec_type  <= T_INT;
                                    rec_valid <= 1'b1;
                                end
                            endcase
                        end
                    end
                    default: state <= ERR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trace_node_parser.sv
// Directed bench for trace_node_parser: header walk, records, skip,
// error codes and asynchronous reset.
module tb_trace_node_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        rec_valid;
    logic        rec_ready = 1'b1;
    logic [31:0] rec_type;
    logic [31:0] rec_data0;
    logic [31:0] rec_data1;
    logic [31:0] rec_data2;
    logic        node_done;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int viol = 0;
    bit toggle = 1'b0;

    logic [31:0] q_type[$];
    logic [31:0] q_d0[$];
    logic [31:0] q_d1[$];
    logic [31:0] q_d2[$];

    trace_node_parser dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_type(rec_type), .rec_data0(rec_data0),
        .rec_data1(rec_data1), .rec_data2(rec_data2),
        .node_done(node_done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Capture every handshake and node_done pulse at the active edge.
    always @(posedge clk) begin
        if (!rst) begin
            if (rec_valid && rec_ready) begin
                q_type.push_back(rec_type);
                q_d0.push_back(rec_data0);
                q_d1.push_back(rec_data1);
                q_d2.push_back(rec_data2);
            end
            if (node_done) done_cnt++;
        end
    end

    task automatic clear_log();
        q_type.delete();
        q_d0.delete();
        q_d1.delete();
        q_d2.delete();
        done_cnt = 0;
        viol = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Entered and left on a negedge; the word is taken at the posedge between.
    task automatic send(input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (toggle) rec_ready = ~rec_ready;
            #1;
            if (rec_valid && !rec_ready && in_ready) viol++;
            if (in_ready) ok = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout word=%h in_ready never high", d);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (toggle) rec_ready = ~rec_ready;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({rec_valid, node_done, err, err_code} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {rec_valid, node_done, err, err_code});
        end
        checks++;
        if ({rec_type, rec_data0, rec_data1, rec_data2} !== 128'd0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h/%h want 0",
                     rec_type, rec_data0, rec_data1, rec_data2);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        do_reset();
    endtask

    task automatic test_basic();
        clear_log();
        rec_ready = 1'b1;
        send(32); send(0); send(1); send(0);
        send(100); send(7); send(32'h13); send(0);
        idle(3);
        checks++;
        if (q_type.size() !== 1) begin
            errors++;
            $display("FAIL basic_count got %0d want 1", q_type.size());
        end else begin
            checks++;
            if ({q_type[0], q_d0[0], q_d1[0], q_d2[0]} !==
                {32'd1, 32'd100, 32'd7, 32'h13}) begin
                errors++;
                $display("FAIL basic_rec got %h %h %h %h want 1 64 7 13",
                         q_type[0], q_d0[0], q_d1[0], q_d2[0]);
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL basic_done got %0d want 1", done_cnt);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL basic_err got %b want 0", err);
        end
    endtask

    task automatic test_intreg();
        int bad;
        clear_log();
        toggle = 1'b1;
        send(144); send(0); send(4); send(0);
        for (int i = 0; i < 32; i++) send(i * 3);
        idle(10);
        toggle = 1'b0;
        rec_ready = 1'b1;
        idle(2);
        checks++;
        if (q_type.size() !== 32) begin
            errors++;
            $display("FAIL intreg_count got %0d want 32", q_type.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 32; i++)
                if (q_type[i] !== 32'd4 || q_d0[i] !== i ||
                    q_d1[i] !== i * 3 || q_d2[i] !== 32'd0)
                    bad++;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL intreg_recs got %0d bad want 0", bad);
            end
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL intreg_hold got %0d ready-while-held want 0", viol);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL intreg_done got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_skip_then_pc();
        clear_log();
        rec_ready = 1'b1;
        send(40); send(0); send(13); send(0);
        for (int i = 0; i < 6; i++) send(32'hA000_0000 + i);
        send(24); send(0); send(2); send(0);
        send(32'h8000_0000); send(32'h8000_0000);
        idle(3);
        checks++;
        if (q_type.size() !== 1) begin
            errors++;
            $display("FAIL skip_count got %0d want 1", q_type.size());
        end else begin
            checks++;
            if ({q_type[0], q_d0[0], q_d1[0], q_d2[0]} !==
                {32'd2, 32'h8000_0000, 32'h8000_0000, 32'd0}) begin
                errors++;
                $display("FAIL pc_rec got %h %h %h %h want 2 80000000 80000000 0",
                         q_type[0], q_d0[0], q_d1[0], q_d2[0]);
            end
        end
        checks++;
        if (done_cnt !== 2) begin
            errors++;
            $display("FAIL skip_done got %0d want 2", done_cnt);
        end
    endtask

    task automatic test_err_size_high();
        send(32); send(1);
        #1;
        checks++;
        if ({err, err_code, in_ready} !== 4'b1010) begin
            errors++;
            $display("FAIL szhi_err got err=%b code=%0d rdy=%b want 1 1 0",
                     err, err_code, in_ready);
        end
        in_valid = 1'b1;
        in_data = 32'h1234;
        idle(5);
        #1;
        checks++;
        if ({err, err_code, in_ready} !== 4'b1010) begin
            errors++;
            $display("FAIL szhi_hold got err=%b code=%0d rdy=%b want 1 1 0",
                     err, err_code, in_ready);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({err, err_code, in_ready, rec_valid, node_done} !== 6'b000100) begin
            errors++;
            $display("FAIL szhi_rst got %b want 000100",
                     {err, err_code, in_ready, rec_valid, node_done});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_size_errors();
        send(28); send(0); send(12);
        #1;
        checks++;
        if ({err, err_code} !== 3'b111) begin
            errors++;
            $display("FAIL io_size got err=%b code=%0d want 1 3", err, err_code);
        end
        do_reset();
        send(18); send(0); send(5);
        #1;
        checks++;
        if ({err, err_code} !== 3'b110) begin
            errors++;
            $display("FAIL bad_size got err=%b code=%0d want 1 2", err, err_code);
        end
        do_reset();
    endtask

    task automatic test_reset_midpayload();
        clear_log();
        rec_ready = 1'b0;
        send(32); send(0); send(1); send(0);
        send(1); send(2); send(3); send(4);
        #1;
        checks++;
        if (rec_valid !== 1'b1) begin
            errors++;
            $display("FAIL pend_valid got %b want 1", rec_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++;
            $display("FAIL pend_rst got %b want 0", rec_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        rec_ready = 1'b1;
        clear_log();
        send(24); send(0); send(12); send(0);
        send(32'hDEAD); send(0);
        idle(3);
        checks++;
        if (q_type.size() !== 1) begin
            errors++;
            $display("FAIL io_count got %0d want 1", q_type.size());
        end else begin
            checks++;
            if ({q_type[0], q_d0[0], q_d1[0], q_d2[0]} !==
                {32'd12, 32'hDEAD, 32'd0, 32'd0}) begin
                errors++;
                $display("FAIL io_rec got %h %h %h %h want c dead 0 0",
                         q_type[0], q_d0[0], q_d1[0], q_d2[0]);
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL io_done got %0d want 1", done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_intreg();
        test_skip_then_pc();
        test_err_size_high();
        test_size_errors();
        test_reset_midpayload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
